// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet stat path.
// Contents: event codes (the bit index of each source in the pending
// vector), the number of sources, sensor active levels, the arbiter
// FSM state type, and the round-robin successor helper.
package tamagotchi_pkg;

    localparam int NUM_SRC = 7;

    localparam logic [2:0] EV_DAY   = 3'd0;
    localparam logic [2:0] EV_DECAY = 3'd1;
    localparam logic [2:0] EV_COMER = 3'd2;
    localparam logic [2:0] EV_CURAR = 3'd3;
    localparam logic [2:0] EV_TEMP  = 3'd4;
    localparam logic [2:0] EV_LUZ   = 3'd5;
    localparam logic [2:0] EV_PROX  = 3'd6;

    // Codes EV_COMER..EV_PROX share the round-robin ring.
    localparam logic [2:0] RR_FIRST = EV_COMER;
    localparam logic [2:0] RR_LAST  = EV_PROX;

    localparam logic TEMP_ACTIVE = 1'b0;
    localparam logic LUZ_ACTIVE  = 1'b0;
    localparam logic PROX_ACTIVE = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // Next code on the round-robin ring, wrapping the last code back to the first.
    function automatic logic [2:0] rr_next(input logic [2:0] code);
        return (code == RR_LAST) ? RR_FIRST : code + 3'd1;
    endfunction

endpackage

// File: rtl/stat_event_arbiter_if.sv
// Bundle between the event sources, the arbiter and the stat bank.
// master: the arbiter (takes requests and ev_ready, drives the event
//         stream, pending vector and drop counter).
// slave : the environment (sources plus bank), the mirror image.
interface stat_event_arbiter_if #(
    parameter int DROP_W = 8
);
    import tamagotchi_pkg::*;

    logic                dead;
    logic                tick_day;
    logic                tick_decay;
    logic                tick_base;
    logic                btn_comer;
    logic                btn_curar;
    logic                sns_temp;
    logic                sns_luz;
    logic                sns_prox;
    logic                ev_valid;
    logic [2:0]          ev_id;
    logic                ev_ready;
    logic [NUM_SRC-1:0]  pending;
    logic [DROP_W-1:0]   drop_cnt;

    modport master (
        input  dead, tick_day, tick_decay, tick_base, btn_comer, btn_curar,
               sns_temp, sns_luz, sns_prox, ev_ready,
        output ev_valid, ev_id, pending, drop_cnt
    );

    modport slave (
        output dead, tick_day, tick_decay, tick_base, btn_comer, btn_curar,
               sns_temp, sns_luz, sns_prox, ev_ready,
        input  ev_valid, ev_id, pending, drop_cnt
    );

endinterface

// File: rtl/sensor_cooldown.sv
// Arm flag and cooldown down-counter for one level sensor.
// Ports: clk, rst (sync, active-low); level (raw sensor input);
//        active (level meaning "asserted"); grant (bank accepted this
//        sensor's event); tick_base (cooldown time base pulse);
//        fire (sensor is armed and at its active level).
module sensor_cooldown #(
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic active,
    input  logic grant,
    input  logic tick_base,
    output logic fire
);

    localparam int CNT_W = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    logic             armed;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed <= 1'b1;
            cnt   <= '0;
        end else if (grant) begin
            armed <= 1'b0;
            cnt   <= CNT_W'(COOLDOWN_TICKS);
        end else if (!armed && tick_base) begin
            // The tick that takes the count to zero is the one that re-arms.
            if (cnt <= CNT_W'(1)) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign fire = armed && (level == active);

endmodule

// File: rtl/stat_event_arbiter.sv
// Serialises stat-update requests (day/decay ticks, feed/heal buttons,
// temperature/light/proximity sensors) into one event stream for the
// stat bank. DAY beats DECAY beats a round-robin ring over codes 2..6.
// Ports: clk; rst (sync, active-low); bus (master side of
//        stat_event_arbiter_if: requests, dead, ev_valid/ev_id/ev_ready
//        handshake, pending vector, saturating drop counter).
module stat_event_arbiter
    import tamagotchi_pkg::*;
#(
    parameter int COOLDOWN_TICKS = 4,
    parameter int DROP_W         = 8
) (
    input logic                 clk,
    input logic                 rst,
    stat_event_arbiter_if.master bus
);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] drop;
    logic [2:0]         fire;
    logic [2:0]         grant_sns;
    logic [2:0]         sns_level;
    logic [2:0]         sns_active;
    logic               accept;
    logic [2:0]         rr_ptr;
    logic [2:0]         winner;
    logic [2:0]         cand;
    logic               found;
    arb_state_t         state;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [2:0]        b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W + 1)'(b);
        return s[DROP_W] ? '1 : s[DROP_W-1:0];
    endfunction

    // A dead pet blocks the handshake as well as new requests.
    assign accept = bus.ev_valid && bus.ev_ready && !bus.dead;

    assign sns_level  = {bus.sns_prox, bus.sns_luz, bus.sns_temp};
    assign sns_active = {PROX_ACTIVE, LUZ_ACTIVE, TEMP_ACTIVE};

    for (genvar s = 0; s < 3; s++) begin : g_sns
        assign grant_sns[s] = accept && (bus.ev_id == (EV_TEMP + 3'(s)));

        sensor_cooldown #(
            .COOLDOWN_TICKS(COOLDOWN_TICKS)
        ) u_cooldown (
            .clk       (clk),
            .rst       (rst),
            .level     (sns_level[s]),
            .active    (sns_active[s]),
            .grant     (grant_sns[s]),
            .tick_base (bus.tick_base),
            .fire      (fire[s])
        );
    end

    always_comb begin
        req            = '0;
        req[EV_DAY]    = bus.tick_day;
        req[EV_DECAY]  = bus.tick_decay;
        req[EV_COMER]  = bus.btn_comer;
        req[EV_CURAR]  = bus.btn_curar;
        // A held sensor level is one outstanding request, not one per
        // cycle, so an armed sensor only requests while it is not pending.
        req[EV_TEMP]   = fire[0] && !bus.pending[EV_TEMP];
        req[EV_LUZ]    = fire[1] && !bus.pending[EV_LUZ];
        req[EV_PROX]   = fire[2] && !bus.pending[EV_PROX];
        clr            = accept ? (NUM_SRC'(1) << bus.ev_id) : '0;
        // A set landing on the bit being cleared wins and is not a drop.
        drop           = req & bus.pending & ~clr;
    end

    // Rotating priority picker; only consulted in IDLE.
    always_comb begin
        winner = EV_DAY;
        cand   = rr_ptr;
        found  = 1'b0;
        if (bus.pending[EV_DAY]) begin
            winner = EV_DAY;
        end else if (bus.pending[EV_DECAY]) begin
            winner = EV_DECAY;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (!found && bus.pending[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
                cand = rr_next(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.pending  <= '0;
            bus.drop_cnt <= '0;
            bus.ev_valid <= 1'b0;
            bus.ev_id    <= EV_DAY;
            rr_ptr       <= RR_FIRST;
            state        <= ST_IDLE;
        end else begin
            if (bus.dead) begin
                bus.pending <= '0;
            end else begin
                bus.pending  <= (bus.pending & ~clr) | req;
                bus.drop_cnt <= sat_add(bus.drop_cnt, 3'($countones(drop)));
            end

            case (state)
                ST_IDLE: begin
                    if (!bus.dead && (|bus.pending)) begin
                        bus.ev_id    <= winner;
                        bus.ev_valid <= 1'b1;
                        state        <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.dead) begin
                        bus.ev_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (bus.ev_ready) begin
                        bus.ev_valid <= 1'b0;
                        state        <= ST_IDLE;
                        if (bus.ev_id >= RR_FIRST) begin
                            rr_ptr <= rr_next(bus.ev_id);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_event_arbiter.sv
// Bench for stat_event_arbiter: directed stimulus, a spec-level model
// checked every cycle, and literal expectations for each scenario.
module tb_stat_event_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;
    logic cmp_en;

    logic [2:0] evq[$];
    int         evc[$];

    stat_event_arbiter_if #(.DROP_W(8)) bus ();

    stat_event_arbiter #(
        .COOLDOWN_TICKS(4),
        .DROP_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- spec-level model ----------------
    typedef struct packed {
        logic [6:0]      pend;
        logic            offer;
        logic [2:0]      id;
        logic [2:0]      rr;
        logic [7:0]      drops;
        logic [2:0]      armed;
        logic [2:0][2:0] cd;
    } mstate_t;

    mstate_t m;

    function automatic logic [2:0] m_pick(input logic [6:0] p, input logic [2:0] rr);
        if (p[0]) return 3'd0;
        if (p[1]) return 3'd1;
        for (int k = 0; k < 5; k++) begin
            int c;
            c = 2 + ((int'(rr) - 2 + k) % 5);
            if (p[c]) return 3'(c);
        end
        return 3'd0;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic rst_n, input logic dead_i,
                                           input logic day, input logic decay, input logic base,
                                           input logic comer, input logic curar, input logic temp,
                                           input logic luz, input logic prox, input logic ready);
        mstate_t    n;
        logic [6:0] want;
        logic [2:0] act;
        logic       acc;
        logic       cleared;
        int         d;
        n = s;
        d = 0;
        if (!rst_n) begin
            n       = '0;
            n.rr    = 3'd2;
            n.armed = 3'b111;
            return n;
        end
        acc = s.offer && ready && !dead_i;
        act = {prox == 1'b1, luz == 1'b0, temp == 1'b0};
        for (int k = 0; k < 3; k++) begin
            if (acc && int'(s.id) == 4 + k) begin
                n.armed[k] = 1'b0;
                n.cd[k]    = 3'd4;
            end else if (!s.armed[k] && base) begin
                if (s.cd[k] > 1) n.cd[k] = s.cd[k] - 3'd1;
                else begin
                    n.cd[k]    = 3'd0;
                    n.armed[k] = 1'b1;
                end
            end
        end
        want = {3'b000, curar, comer, decay, day};
        for (int k = 0; k < 3; k++)
            if (s.armed[k] && act[k] && !s.pend[4 + k]) want[4 + k] = 1'b1;
        if (dead_i) begin
            n.pend = '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                cleared = acc && int'(s.id) == i;
                if (want[i]) begin
                    if (s.pend[i] && !cleared) d++;
                    n.pend[i] = 1'b1;
                end else if (cleared) begin
                    n.pend[i] = 1'b0;
                end
            end
        end
        n.drops = (int'(s.drops) + d > 255) ? 8'd255 : 8'(int'(s.drops) + d);
        if (s.offer) begin
            if (dead_i) n.offer = 1'b0;
            else if (ready) begin
                n.offer = 1'b0;
                if (s.id >= 3'd2) n.rr = (s.id == 3'd6) ? 3'd2 : s.id + 3'd1;
            end
        end else if (!dead_i && s.pend != 7'd0) begin
            n.offer = 1'b1;
            n.id    = m_pick(s.pend, s.rr);
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, rst, bus.dead, bus.tick_day, bus.tick_decay, bus.tick_base,
                        bus.btn_comer, bus.btn_curar, bus.sns_temp, bus.sns_luz,
                        bus.sns_prox, bus.ev_ready);

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model ev_valid", 32'(bus.ev_valid), 32'(m.offer));
            check("model ev_id", 32'(bus.ev_id), 32'(m.id));
            check("model pending", 32'(bus.pending), 32'(m.pend));
            check("model drop_cnt", 32'(bus.drop_cnt), 32'(m.drops));
        end
    end

    // Record every accepted event with its cycle.
    always @(negedge clk) begin
        if (cmp_en && rst && bus.ev_valid && bus.ev_ready && !bus.dead) begin
            evq.push_back(bus.ev_id);
            evc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base;
        int ntemp;
        n_tests        = 0;
        n_fail         = 0;
        cyc            = 0;
        cmp_en         = 1'b0;
        rst            = 1'b0;
        bus.dead       = 1'b0;
        bus.tick_day   = 1'b0;
        bus.tick_decay = 1'b0;
        bus.tick_base  = 1'b0;
        bus.btn_comer  = 1'b0;
        bus.btn_curar  = 1'b0;
        bus.sns_temp   = 1'b1;
        bus.sns_luz    = 1'b1;
        bus.sns_prox   = 1'b0;
        bus.ev_ready   = 1'b1;

        step();
        cmp_en = 1'b1;
        steps(2);
        @(negedge clk);
        check("reset pending", 32'(bus.pending), 32'd0);
        check("reset ev_valid", 32'(bus.ev_valid), 32'd0);
        check("reset ev_id", 32'(bus.ev_id), 32'd0);
        check("reset drop_cnt", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b1;
        steps(7);

        // Single request: pulse, pending next cycle, offer two cycles later.
        bus.btn_comer = 1'b1;
        step();
        bus.btn_comer = 1'b0;
        @(negedge clk);
        check("single pending set", 32'(bus.pending), 32'h04);
        check("single not yet valid", 32'(bus.ev_valid), 32'd0);
        step();
        @(negedge clk);
        check("single ev_valid", 32'(bus.ev_valid), 32'd1);
        check("single ev_id", 32'(bus.ev_id), 32'd2);
        step();
        @(negedge clk);
        check("single pending clear", 32'(bus.pending[2]), 32'd0);
        check("single valid drop", 32'(bus.ev_valid), 32'd0);
        steps(3);

        // Fixed priority: DAY, DECAY, then CURAR, one per 2 cycles.
        base = evq.size();
        bus.tick_day   = 1'b1;
        bus.tick_decay = 1'b1;
        bus.btn_curar  = 1'b1;
        step();
        bus.tick_day   = 1'b0;
        bus.tick_decay = 1'b0;
        bus.btn_curar  = 1'b0;
        steps(10);
        check("prio count", 32'(evq.size() - base), 32'd3);
        if (evq.size() - base == 3) begin
            check("prio first", 32'(evq[base]), 32'd0);
            check("prio second", 32'(evq[base + 1]), 32'd1);
            check("prio third", 32'(evq[base + 2]), 32'd3);
            check("prio spacing a", 32'(evc[base + 1] - evc[base]), 32'd2);
            check("prio spacing b", 32'(evc[base + 2] - evc[base + 1]), 32'd2);
        end

        // Round robin: two rounds of COMER+CURAR, then COMER+PROX from rr_ptr=4.
        base = evq.size();
        for (int r = 0; r < 2; r++) begin
            bus.btn_comer = 1'b1;
            bus.btn_curar = 1'b1;
            step();
            bus.btn_comer = 1'b0;
            bus.btn_curar = 1'b0;
            steps(8);
        end
        bus.btn_comer = 1'b1;
        bus.sns_prox  = 1'b1;
        step();
        bus.btn_comer = 1'b0;
        bus.sns_prox  = 1'b0;
        steps(8);
        check("rr count", 32'(evq.size() - base), 32'd6);
        if (evq.size() - base == 6) begin
            check("rr r1 a", 32'(evq[base]), 32'd2);
            check("rr r1 b", 32'(evq[base + 1]), 32'd3);
            check("rr r2 a", 32'(evq[base + 2]), 32'd2);
            check("rr r2 b", 32'(evq[base + 3]), 32'd3);
            check("rr from4 a", 32'(evq[base + 4]), 32'd6);
            check("rr from4 b", 32'(evq[base + 5]), 32'd2);
        end

        // Set and clear of the same bit in one cycle: set wins, no drop.
        base = evq.size();
        bus.btn_comer = 1'b1;
        step();
        bus.btn_comer = 1'b0;
        step();
        bus.btn_comer = 1'b1;
        step();
        bus.btn_comer = 1'b0;
        @(negedge clk);
        check("setclr pending", 32'(bus.pending), 32'h04);
        check("setclr no drop", 32'(bus.drop_cnt), 32'd0);
        steps(6);
        check("setclr two events", 32'(evq.size() - base), 32'd2);

        // Backpressure: three presses while the bank stalls.
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_comer = (i == 0 || i == 5 || i == 10);
            step();
        end
        bus.btn_comer = 1'b0;
        @(negedge clk);
        check("bp drop_cnt", 32'(bus.drop_cnt), 32'd2);
        check("bp held valid", 32'(bus.ev_valid), 32'd1);
        check("bp held id", 32'(bus.ev_id), 32'd2);
        base = evq.size();
        bus.ev_ready = 1'b1;
        steps(6);
        check("bp one event", 32'(evq.size() - base), 32'd1);
        if (evq.size() - base == 1) check("bp event id", 32'(evq[base]), 32'd2);

        // Cooldown: TEMP held active for 100 cycles, tick_base every 10.
        base = evq.size();
        bus.sns_temp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.tick_base = (i % 10 == 9);
            step();
        end
        bus.tick_base = 1'b0;
        bus.sns_temp  = 1'b1;
        steps(6);
        ntemp = 0;
        for (int i = base; i < evq.size(); i++) if (evq[i] == 3'd4) ntemp++;
        check("cooldown temp events", 32'(ntemp), 32'd3);
        check("cooldown total events", 32'(evq.size() - base), 32'd3);

        // dead while offering LUZ.
        bus.ev_ready = 1'b0;
        bus.sns_luz  = 1'b0;
        steps(3);
        @(negedge clk);
        check("dead pre valid", 32'(bus.ev_valid), 32'd1);
        check("dead pre id", 32'(bus.ev_id), 32'd5);
        bus.dead = 1'b1;
        step();
        @(negedge clk);
        check("dead valid drop", 32'(bus.ev_valid), 32'd0);
        check("dead pending", 32'(bus.pending), 32'd0);
        base = evq.size();
        bus.ev_ready  = 1'b1;
        bus.btn_comer = 1'b1;
        bus.tick_day  = 1'b1;
        steps(6);
        bus.btn_comer = 1'b0;
        bus.tick_day  = 1'b0;
        bus.sns_luz   = 1'b1;
        @(negedge clk);
        check("dead no events", 32'(evq.size() - base), 32'd0);
        check("dead drops frozen", 32'(bus.drop_cnt), 32'd2);
        check("dead pending held 0", 32'(bus.pending), 32'd0);
        step();
        bus.dead = 1'b0;
        steps(4);

        // Saturation: COMER held while the bank stalls.
        bus.ev_ready  = 1'b0;
        bus.btn_comer = 1'b1;
        steps(300);
        bus.btn_comer = 1'b0;
        @(negedge clk);
        check("drop saturate", 32'(bus.drop_cnt), 32'd255);
        check("sat held valid", 32'(bus.ev_valid), 32'd1);

        // Reset mid-offer abandons the event.
        rst = 1'b0;
        step();
        @(negedge clk);
        check("rst mid valid", 32'(bus.ev_valid), 32'd0);
        check("rst mid pending", 32'(bus.pending), 32'd0);
        check("rst mid drops", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b1;
        base = evq.size();
        bus.ev_ready = 1'b1;
        steps(5);
        check("rst no event", 32'(evq.size() - base), 32'd0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
